// File: rtl/dp_ram_param.sv
// Parametrised single-clock true dual-port RAM with port enables, selectable
// read-during-write behaviour, optional output register, collision flag and clear sequencer.
module dp_ram_param #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int DEPTH        = 256,
    parameter int RDW_MODE     = 0,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] add_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] add_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              busy,
    output logic              collision
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              coll_q, coll_d;
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_rng_a, in_rng_b;
    logic              user_ok;
    logic              wr_a, wr_b, coll_now;
    logic [IDX_W-1:0]  idx_a, idx_b, idx_clr;
    logic [DATA_W-1:0] ram_a, ram_b;
    logic              clr_wr;

    // Range check on the full address so out-of-range words never alias.
    assign in_rng_a = {1'b0, add_a} < DEPTH_L;
    assign in_rng_b = {1'b0, add_b} < DEPTH_L;
    assign idx_a    = add_a[IDX_W-1:0];
    assign idx_b    = add_b[IDX_W-1:0];
    assign idx_clr  = ptr_q[IDX_W-1:0];
    assign user_ok  = !busy_q && !rst;
    assign wr_a     = user_ok && en_a && we_a && in_rng_a;
    assign wr_b     = user_ok && en_b && we_b && in_rng_b;
    assign coll_now = wr_a && wr_b && (add_a == add_b);
    assign clr_wr   = (state_q == ST_CLEAR) && !rst;
    assign ram_a    = in_rng_a ? mem[idx_a] : '0;
    assign ram_b    = in_rng_b ? mem[idx_b] : '0;

    // Port A is written last so it wins a same-address write collision.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[idx_clr] <= '0;
        end else begin
            if (wr_b) mem[idx_b] <= din_b;
            if (wr_a) mem[idx_a] <= din_a;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        coll_d  = 1'b0;
        rd_a_d  = rd_a_q;
        rd_b_d  = rd_b_q;
        case (state_q)
            ST_CLEAR: begin
                busy_d = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                    ptr_d   = '0;
                end
            end
            default: busy_d = 1'b0;
        endcase
        if (user_ok) begin
            coll_d = coll_now;
            if (en_a) begin
                if (!in_rng_a)
                    rd_a_d = '0;
                else if (RDW_MODE == 1 && we_a)
                    rd_a_d = din_a;
                else
                    rd_a_d = ram_a;
            end
            if (en_b) begin
                // On a collision the stored value is port A's data.
                if (!in_rng_b)
                    rd_b_d = '0;
                else if (RDW_MODE == 1 && we_b)
                    rd_b_d = coll_now ? din_a : din_b;
                else
                    rd_b_d = ram_b;
            end
        end else begin
            rd_a_d = '0;
            rd_b_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            coll_q  <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            coll_q  <= coll_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] out_a_q, out_a_d;
            logic [DATA_W-1:0] out_b_q, out_b_d;
            always_comb begin
                out_a_d = rd_a_q;
                out_b_d = rd_b_q;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_a_q <= '0;
                    out_b_q <= '0;
                end else begin
                    out_a_q <= out_a_d;
                    out_b_q <= out_b_d;
                end
            end
            assign dout_a = out_a_q;
            assign dout_b = out_b_q;
        end else begin : g_no_out_reg
            assign dout_a = rd_a_q;
            assign dout_b = rd_b_q;
        end
    endgenerate

    assign busy      = busy_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_dp_ram_param.sv
// Scoreboard bench for dp_ram_param: three configurations (defaults; DEPTH=16 write-first
// with output register; DEPTH=200), expected responses queued with their due cycle.
module tb_dp_ram_param;

    localparam int K_DA = 0, K_DB = 1, K_BUSY = 2, K_COLL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst    [3];
    logic       en_a   [3];
    logic       we_a   [3];
    logic [7:0] add_a  [3];
    logic [7:0] din_a  [3];
    logic [7:0] dout_a [3];
    logic       en_b   [3];
    logic       we_b   [3];
    logic [7:0] add_b  [3];
    logic [7:0] din_b  [3];
    logic [7:0] dout_b [3];
    logic       busy   [3];
    logic       coll   [3];

    dp_ram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u0 (
        .clk(clk), .rst(rst[0]),
        .en_a(en_a[0]), .we_a(we_a[0]), .add_a(add_a[0]), .din_a(din_a[0]), .dout_a(dout_a[0]),
        .en_b(en_b[0]), .we_b(we_b[0]), .add_b(add_b[0]), .din_b(din_b[0]), .dout_b(dout_b[0]),
        .busy(busy[0]), .collision(coll[0]));

    dp_ram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)) u1 (
        .clk(clk), .rst(rst[1]),
        .en_a(en_a[1]), .we_a(we_a[1]), .add_a(add_a[1]), .din_a(din_a[1]), .dout_a(dout_a[1]),
        .en_b(en_b[1]), .we_b(we_b[1]), .add_b(add_b[1]), .din_b(din_b[1]), .dout_b(dout_b[1]),
        .busy(busy[1]), .collision(coll[1]));

    dp_ram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u2 (
        .clk(clk), .rst(rst[2]),
        .en_a(en_a[2]), .we_a(we_a[2]), .add_a(add_a[2]), .din_a(din_a[2]), .dout_a(dout_a[2]),
        .en_b(en_b[2]), .we_b(we_b[2]), .add_b(add_b[2]), .din_b(din_b[2]), .dout_b(dout_b[2]),
        .busy(busy[2]), .collision(coll[2]));

    typedef struct {
        int         dut;
        int         kind;
        logic [7:0] val;
        int         due;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string kname [4] = '{"dout_a", "dout_b", "busy", "collision"};

    task automatic push(input int d, input int k, input logic [7:0] v, input int due);
        exp_t e;
        e.dut  = d;
        e.kind = k;
        e.val  = v;
        e.due  = due;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] actual(input int d, input int k);
        case (k)
            K_DA:    return dout_a[d];
            K_DB:    return dout_b[d];
            K_BUSY:  return {7'b0, busy[d]};
            default: return {7'b0, coll[d]};
        endcase
    endfunction

    function automatic logic [7:0] pat(input int a);
        return (a < 8) ? 8'(a * 3) : 8'((a - 8) * 5);
    endfunction

    // Monitor: every falling edge, compare and retire all entries due this cycle.
    initial begin
        int         i;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].due <= cyc) begin
                    act = actual(sb[i].dut, sb[i].kind);
                    checks++;
                    if (sb[i].due < cyc || act !== sb[i].val) begin
                        errors++;
                        $display("FAIL u%0d %s cyc=%0d: got %02h expected %02h",
                                 sb[i].dut, kname[sb[i].kind], cyc, act, sb[i].val);
                    end else begin
                        $display("ok   u%0d %s cyc=%0d: %02h", sb[i].dut, kname[sb[i].kind], cyc, act);
                    end
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d,
                         input logic ea, input logic wa, input logic [7:0] aa, input logic [7:0] da,
                         input logic eb, input logic wb, input logic [7:0] ab, input logic [7:0] db);
        en_a[d] = ea; we_a[d] = wa; add_a[d] = aa; din_a[d] = da;
        en_b[d] = eb; we_b[d] = wb; add_b[d] = ab; din_b[d] = db;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) drive(d, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        int c0;
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        idle_all();
        tick();
        tick();
        tick();
        // Reset state of every instance.
        for (int d = 0; d < 3; d++) begin
            push(d, K_BUSY, 8'h01, cyc);
            push(d, K_DA, 8'h00, cyc);
            push(d, K_DB, 8'h00, cyc);
            push(d, K_COLL, 8'h00, cyc);
        end
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        c0 = cyc;
        push(0, K_BUSY, 8'h01, c0 + 255);
        push(0, K_BUSY, 8'h00, c0 + 256);
        push(1, K_BUSY, 8'h01, c0 + 15);
        push(1, K_BUSY, 8'h00, c0 + 16);
        push(2, K_BUSY, 8'h01, c0 + 199);
        push(2, K_BUSY, 8'h00, c0 + 200);
        repeat (260) tick();

        // u0: defaults, 1-cycle latency, read-first.
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 1, 8'(i), 8'(i * 3), 1, 1, 8'(8 + i), 8'(i * 5));
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 8'(i), 8'h00, 1, 0, 8'(15 - i), 8'h00);
            push(0, K_DA, pat(i), cyc + 1);
            push(0, K_DB, pat(15 - i), cyc + 1);
            tick();
        end
        drive(0, 0, 0, 8'h03, 8'h00, 0, 0, 8'h04, 8'h00);
        push(0, K_DA, pat(15), cyc + 1);
        push(0, K_DB, pat(0), cyc + 1);
        tick();
        drive(0, 1, 1, 8'h20, 8'hAA, 1, 1, 8'h20, 8'h55);
        push(0, K_COLL, 8'h01, cyc + 1);
        push(0, K_DA, 8'h00, cyc + 1);
        push(0, K_DB, 8'h00, cyc + 1);
        tick();
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        push(0, K_COLL, 8'h00, cyc + 1);
        tick();
        drive(0, 1, 0, 8'h20, 8'h00, 1, 0, 8'h20, 8'h00);
        push(0, K_DA, 8'hAA, cyc + 1);
        push(0, K_DB, 8'hAA, cyc + 1);
        tick();
        drive(0, 1, 1, 8'h07, 8'h11, 0, 0, 8'h00, 8'h00);
        push(0, K_DA, pat(7), cyc + 1);
        tick();
        drive(0, 1, 1, 8'h07, 8'h22, 1, 0, 8'h07, 8'h00);
        push(0, K_DA, 8'h11, cyc + 1);
        push(0, K_DB, 8'h11, cyc + 1);
        tick();
        drive(0, 1, 0, 8'h07, 8'h00, 1, 0, 8'h07, 8'h00);
        push(0, K_DA, 8'h22, cyc + 1);
        push(0, K_DB, 8'h22, cyc + 1);
        tick();
        idle_all();
        tick();

        // u1: DEPTH=16, write-first, 2-cycle latency.
        drive(1, 1, 1, 8'h03, 8'h5A, 1, 1, 8'h09, 8'hC3);
        push(1, K_DA, 8'h5A, cyc + 2);
        push(1, K_DB, 8'hC3, cyc + 2);
        tick();
        drive(1, 1, 1, 8'h07, 8'h11, 0, 0, 8'h00, 8'h00);
        push(1, K_DA, 8'h11, cyc + 2);
        tick();
        drive(1, 1, 1, 8'h07, 8'h22, 1, 0, 8'h07, 8'h00);
        push(1, K_DA, 8'h22, cyc + 2);
        push(1, K_DB, 8'h11, cyc + 2);
        tick();
        drive(1, 1, 1, 8'h02, 8'hAA, 1, 1, 8'h02, 8'h55);
        push(1, K_DA, 8'hAA, cyc + 2);
        push(1, K_DB, 8'hAA, cyc + 2);
        push(1, K_COLL, 8'h01, cyc + 1);
        tick();
        drive(1, 1, 0, 8'h03, 8'h00, 1, 0, 8'h02, 8'h00);
        push(1, K_DA, 8'h5A, cyc + 2);
        push(1, K_DB, 8'hAA, cyc + 2);
        push(1, K_COLL, 8'h00, cyc + 1);
        tick();
        drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        push(1, K_DA, 8'h5A, cyc + 2);
        push(1, K_DB, 8'hAA, cyc + 2);
        tick();
        tick();
        tick();

        // u1: reset with nonzero contents, then full clear.
        rst[1] = 1'b1;
        tick();
        tick();
        push(1, K_DA, 8'h00, cyc);
        push(1, K_BUSY, 8'h01, cyc);
        rst[1] = 1'b0;
        c0 = cyc;
        push(1, K_BUSY, 8'h01, c0 + 15);
        push(1, K_BUSY, 8'h00, c0 + 16);
        repeat (16) tick();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 8'(i), 8'h00, 1, 0, 8'(15 - i), 8'h00);
            push(1, K_DA, 8'h00, cyc + 2);
            push(1, K_DB, 8'h00, cyc + 2);
            tick();
        end
        drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        // u1: reset during the clear sequence restarts it.
        rst[1] = 1'b1;
        tick();
        tick();
        rst[1] = 1'b0;
        repeat (5) tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        c0 = cyc;
        push(1, K_BUSY, 8'h01, c0);
        push(1, K_BUSY, 8'h01, c0 + 15);
        push(1, K_BUSY, 8'h00, c0 + 16);
        repeat (18) tick();

        // u2: DEPTH=200, out-of-range accesses.
        drive(2, 1, 1, 8'd10, 8'h3C, 0, 0, 8'h00, 8'h00);
        push(2, K_DA, 8'h00, cyc + 1);
        tick();
        drive(2, 1, 1, 8'd210, 8'hFF, 1, 1, 8'd199, 8'h77);
        push(2, K_DA, 8'h00, cyc + 1);
        push(2, K_DB, 8'h00, cyc + 1);
        tick();
        drive(2, 1, 0, 8'd210, 8'h00, 1, 0, 8'd10, 8'h00);
        push(2, K_DA, 8'h00, cyc + 1);
        push(2, K_DB, 8'h3C, cyc + 1);
        tick();
        drive(2, 1, 1, 8'd210, 8'h01, 1, 1, 8'd210, 8'h02);
        push(2, K_COLL, 8'h00, cyc + 1);
        push(2, K_DA, 8'h00, cyc + 1);
        push(2, K_DB, 8'h00, cyc + 1);
        tick();
        drive(2, 1, 0, 8'd199, 8'h00, 1, 0, 8'd210, 8'h00);
        push(2, K_DA, 8'h77, cyc + 1);
        push(2, K_DB, 8'h00, cyc + 1);
        tick();
        idle_all();
        repeat (5) tick();

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_ram_param.md
Name: dp_ram_param

Overview:
Parametrised single-clock true dual-port RAM. It is the successor to the existing fixed 8x8-bit dual-port memory. It adds configurable width and depth, port enables, and selectable read-during-write mode. It also adds an optional output pipeline register, write-write collision detection, and a built-in clear-on-reset sequencer. It serves as the general scratch/buffer memory for datapath blocks that need two independent access ports on one clock.

Parameters:
DATA_W, 8, data width in bits per word
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency
CLEAR_ON_RST, 1, 1 = zero all words after reset via sequencer; 0 = contents untouched by reset

Ports:
clk  input  1  single clock for both ports; all logic on rising edge
rst  input  1  synchronous active-high reset
en_a  input  1  port A access enable
we_a  input  1  port A write enable; qualified by en_a
add_a  input  ADDR_W  port A address
din_a  input  DATA_W  port A write data
dout_a  output  DATA_W  port A read data
en_b  input  1  port B access enable
we_b  input  1  port B write enable; qualified by en_b
add_b  input  ADDR_W  port B address
din_b  input  DATA_W  port B write data
dout_b  output  DATA_W  port B read data
busy  output  1  high while in reset or clear sequence; port accesses ignored
collision  output  1  one-cycle pulse: both ports wrote the same address

Behaviour:
- Reset (rst=1 at a clock edge):
  - dout_a, dout_b, collision and all pipeline stages go to 0.
  - busy=1.
  - Clear pointer goes to 0.
  - FSM goes to CLEAR if CLEAR_ON_RST=1, else to RUN.
- FSM states:
  - CLEAR: while rst is low, each cycle writes 0 to address ptr, then ptr++. When ptr==DEPTH-1 is written, go to RUN. busy stays 1 for exactly DEPTH cycles after rst deasserts; it reads 0 in the cycle after the last clear write.
  - RUN: busy=0; normal port operation.
- rst asserted mid-CLEAR: ptr returns to 0 and clearing restarts from address 0 after rst falls.
- While busy=1:
  - All en/we inputs are ignored; no user writes occur.
  - dout_a and dout_b hold 0.
- Write: at a clock edge with en_x=1 and we_x=1, mem[add_x] <= din_x.
- Read: with en_x=1, the word at add_x appears on dout_x after 1 edge (OUT_REG=0) or 2 edges (OUT_REG=1).
- With en_x=0: no access; dout_x holds its last value. The pipeline stage also holds.
- Same-port read-during-write:
  - RDW_MODE=0: dout_x shows the pre-write contents.
  - RDW_MODE=1: dout_x shows din_x.
- Cross-port, A writes and B reads the same address in the same cycle:
  - B always gets old data (read-first), independent of RDW_MODE. Symmetric for B writes with A reads.
- Both ports write the same address in the same cycle:
  - Port A data is stored.
  - collision=1 on the following cycle only.
  - Each port's own dout follows its RDW_MODE rule, using port A's data as the new value.
- Both ports read the same address: both get identical data; no collision.
- Address >= DEPTH (possible only when DEPTH < 2**ADDR_W):
  - Write is dropped.
  - Read returns 0.
  - Not counted as a collision.
- No address wrap: out-of-range addresses never alias onto valid words.
- collision is registered and cleared every cycle it is not re-triggered.

Test Plan:
- CLEAR_ON_RST=1, DEPTH=16: preload nonzero data, pulse rst for 2 cycles -> busy=1 for exactly 16 cycles after rst falls; all 16 addresses then read 0.
- Defaults: port A writes addr i with i*3 and port B writes addr 8+i with i*5, for i=0..7; then read all back on both ports -> dout_a(addr 5)=15, dout_b(addr 13)=25; latency 1 cycle, and 2 cycles with OUT_REG=1.
- Both ports write addr 0x20 in one cycle, A=0xAA, B=0x55 -> collision=1 for one cycle; a later read returns 0xAA.
- mem[7]=0x11; port A writes 0x22 to addr 7 while port B reads addr 7 -> dout_b=0x11. Same cycle, dout_a=0x11 (RDW_MODE=0) or 0x22 (RDW_MODE=1).
- DEPTH=200, ADDR_W=8: write 0xFF to addr 210 -> read of addr 210 returns 0; addr 210-200=10 is unchanged.
- rst asserted after 5 clear cycles -> busy stays high; clearing restarts at addr 0; busy lasts DEPTH cycles from the second rst deassertion.
